// File: rtl/m3key_conditioner_pkg.sv
// Shared constants and types for the front-panel key conditioner.
package m3key_conditioner_pkg;

  // Default timing at the 1 MHz control clock
  localparam int DEB_CNT_DEF = 20000;   // 20 ms debounce
  localparam int RPT_DLY_DEF = 500000;  // 0.5 s to first auto-repeat
  localparam int RPT_PER_DEF = 100000;  // 0.1 s auto-repeat period

  // Key bit map of keyNi / keyStableO
  localparam int NUM_KEYS   = 7;
  localparam int KEY_START  = 0;
  localparam int KEY_FSTOP  = 1;
  localparam int KEY_INVROT = 2;
  localparam int KEY_FINC   = 3;
  localparam int KEY_FDEC   = 4;
  localparam int KEY_PINC   = 5;
  localparam int KEY_PDEC   = 6;

  // Step keys occupy KEY_FINC..KEY_PDEC; pairs are (0,1) and (2,3) in step index
  localparam int NUM_LEVEL = 3;
  localparam int NUM_STEP  = 4;
  localparam int STEP_BASE = KEY_FINC;

  // Auto-repeat FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_st_e;

  // Step index of the conflicting partner key (INC <-> DEC of the same pair)
  function automatic int step_partner(input int s);
    return s ^ 1;
  endfunction

  // Counter width able to hold values 0..n-1
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m3key_conditioner_debounce.sv
// One key: invert, 2-flop synchronise, then accept a change only after
// DEB_CNT consecutive cycles of disagreement with the stable value.
module m3key_debounce
  import m3key_conditioner_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic clkI,
  input  logic nRstI,
  input  logic keyNi,
  output logic stableO
);

  localparam int CW = cnt_w(DEB_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // Synchronise the inverted (active-high) raw key into the clock domain
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], ~keyNi};
  end

  // Count disagreement cycles; take the new level once the run is long enough
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync[1] == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt >= CNT_MAX) begin
      r_stable <= r_sync[1];
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stableO = r_stable;

endmodule

// File: rtl/m3key_conditioner.sv
// Front-panel key conditioner: debounced levels for start/forceStop/invRotate
// and single-cycle auto-repeating step pulses for freq/power INC/DEC.
module m3key_conditioner
  import m3key_conditioner_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic [NUM_KEYS-1:0] keyNi,
  output logic                m3startO,
  output logic                m3forceStopO,
  output logic                m3invRotateO,
  output logic                m3freqINCo,
  output logic                m3freqDECo,
  output logic                m3powerINCo,
  output logic                m3powerDECo,
  output logic [NUM_KEYS-1:0] keyStableO
);

  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RCW     = cnt_w(RPT_MAX);
  localparam logic [RCW-1:0] DLY_MAX = RCW'(RPT_DLY - 1);
  localparam logic [RCW-1:0] PER_MAX = RCW'(RPT_PER - 1);

  logic [NUM_KEYS-1:0]  w_stable;
  logic [NUM_STEP-1:0]  w_pls;
  logic [NUM_STEP-1:0]  r_stb_q;
  logic [NUM_STEP-1:0]  r_pulse;
  logic [NUM_LEVEL-1:0] r_level;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    m3key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clkI    (clkI),
      .nRstI   (nRstI),
      .keyNi   (keyNi[k]),
      .stableO (w_stable[k])
    );
  end

  // Per step key: IDLE -> DELAY -> REPEAT auto-repeat FSM.
  // Only a fresh stable rising edge starts a sequence, so a key left pressed
  // after a pair conflict stays silent until it is released and re-pressed.
  for (genvar s = 0; s < NUM_STEP; s++) begin : g_step
    localparam int PAIR = step_partner(s);

    rpt_st_e        r_state, w_state_nxt;
    logic [RCW-1:0] r_cnt, w_cnt_nxt;
    logic           w_stb, w_conf, w_rise, w_pulse;

    assign w_stb  = w_stable[STEP_BASE + s];
    assign w_conf = w_stb & w_stable[STEP_BASE + PAIR];
    assign w_rise = w_stb & ~r_stb_q[s];

    // State and repeat counter register
    always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next state: release or pair conflict forces IDLE immediately
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!w_stb || w_conf) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              w_state_nxt = ST_DELAY;
              w_cnt_nxt   = '0;
            end
          end
          ST_DELAY: begin
            if (r_cnt >= DLY_MAX) begin
              w_state_nxt = ST_REPEAT;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_cnt >= PER_MAX) w_cnt_nxt = '0;
            else                  w_cnt_nxt = r_cnt + 1'b1;
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    // Step request: first press, end of initial delay, end of each period
    always_comb begin
      w_pulse = 1'b0;
      if (w_stb && !w_conf) begin
        case (r_state)
          ST_IDLE:   w_pulse = w_rise;
          ST_DELAY:  w_pulse = (r_cnt >= DLY_MAX);
          ST_REPEAT: w_pulse = (r_cnt >= PER_MAX);
          default:   w_pulse = 1'b0;
        endcase
      end
    end

    assign w_pls[s] = w_pulse;
  end

  // Previous stable step levels for rising-edge detection
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) r_stb_q <= '0;
    else        r_stb_q <= w_stable[STEP_BASE +: NUM_STEP];
  end

  // Output registers; forceStop swallows step pulses without disturbing FSMs
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_level <= '0;
      r_pulse <= '0;
    end else begin
      r_level <= w_stable[NUM_LEVEL-1:0];
      r_pulse <= w_pls & {NUM_STEP{~w_stable[KEY_FSTOP]}};
    end
  end

  assign m3startO     = r_level[KEY_START];
  assign m3forceStopO = r_level[KEY_FSTOP];
  assign m3invRotateO = r_level[KEY_INVROT];
  assign m3freqINCo   = r_pulse[KEY_FINC - STEP_BASE];
  assign m3freqDECo   = r_pulse[KEY_FDEC - STEP_BASE];
  assign m3powerINCo  = r_pulse[KEY_PINC - STEP_BASE];
  assign m3powerDECo  = r_pulse[KEY_PDEC - STEP_BASE];
  assign keyStableO   = w_stable;

endmodule
